// File: rtl/dffn_pkg.sv
// rtl/dffn_pkg.sv - shared limits and occupancy-width helper for the falling-edge pipe
package dffn_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int DEPTH_MAX = 16;

  // Bits needed to count 0..depth occupied stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffnrnq_stage.sv
// rtl/dffnrnq_stage.sv - one falling-edge data stage with valid tag, enable and scan muxing
module dffnrnq_stage
  import dffn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clkn,
  input  logic             rn,
  input  logic             en,
  input  logic             se,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             vin,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic             qv_nxt
);

  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] q_nxt;

  // Scan moves every bit one place towards the MSB, si landing in bit0.
  if (WIDTH == 1) begin : g_shift_1
    assign shift_val = si;
  end else begin : g_shift_n
    assign shift_val = {q[WIDTH-2:0], si};
  end

  always_comb begin
    q_nxt = q;
    if (se) begin
      q_nxt = shift_val;
    end else if (en) begin
      q_nxt = d;
    end
  end

  always_comb begin
    qv_nxt = qv;
    if (flush) begin
      qv_nxt = 1'b0;
    end else if (!se && en) begin
      qv_nxt = vin;
    end
  end

  always_ff @(negedge clkn or negedge rn) begin
    if (!rn) begin
      q  <= '0;
      qv <= 1'b0;
    end else begin
      q  <= q_nxt;
      qv <= qv_nxt;
    end
  end

endmodule

// File: rtl/dffnrnq_pipe.sv
// rtl/dffnrnq_pipe.sv - DEPTH-stage falling-edge pipeline with valid tags, flush, scan chain and occupancy count
module dffnrnq_pipe
  import dffn_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                         CLKN,
  input  logic                         RN,
  input  logic [WIDTH-1:0]             D,
  input  logic                         VIN,
  input  logic                         EN,
  input  logic                         FLUSH,
  input  logic                         SE,
  input  logic                         SI,
  output logic [WIDTH-1:0]             Q,
  output logic                         QV,
  output logic                         SO,
  output logic [occ_width(DEPTH)-1:0]  OCC
);

  localparam int OW = occ_width(DEPTH);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "dffnrnq_pipe: WIDTH out of range 1..32");
  end
  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $fatal(1, "dffnrnq_pipe: DEPTH out of range 1..16");
  end

  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [DEPTH-1:0] stg_vi;
  logic [DEPTH-1:0] stg_si;
  logic [DEPTH-1:0] stg_v;
  logic [DEPTH-1:0] stg_vn;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // Stage 0 takes the pipe inputs; later stages chain off their predecessor,
    // including the scan link from the previous stage's MSB.
    if (k == 0) begin : g_head
      assign stg_d[k]  = D;
      assign stg_vi[k] = VIN;
      assign stg_si[k] = SI;
    end else begin : g_body
      assign stg_d[k]  = stg_q[k-1];
      assign stg_vi[k] = stg_v[k-1];
      assign stg_si[k] = stg_q[k-1][WIDTH-1];
    end

    dffnrnq_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clkn   (CLKN),
      .rn     (RN),
      .en     (EN),
      .se     (SE),
      .flush  (FLUSH),
      .d      (stg_d[k]),
      .vin    (stg_vi[k]),
      .si     (stg_si[k]),
      .q      (stg_q[k]),
      .qv     (stg_v[k]),
      .qv_nxt (stg_vn[k])
    );
  end

  // Count the next valid vector so OCC lands on the same edge as the tags.
  logic [OW-1:0] occ_nxt;

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OW'(stg_vn[i]);
    end
  end

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) begin
      OCC <= '0;
    end else begin
      OCC <= occ_nxt;
    end
  end

  assign Q  = stg_q[DEPTH-1];
  assign QV = stg_v[DEPTH-1];
  assign SO = stg_q[DEPTH-1][WIDTH-1];

endmodule

// File: tb/tb_dffnrnq_pipe.sv
// tb/tb_dffnrnq_pipe.sv - directed self-checking bench for dffnrnq_pipe
module tb_dffnrnq_pipe;

  logic       clkn;
  logic       rn;
  logic [3:0] d;
  logic       vin, en, flush, se, si;
  logic [3:0] q;
  logic       qv, so;
  logic [1:0] occ;

  logic       d1, vin1, en1, flush1, se1, si1;
  logic       q1, qv1, so1;
  logic [0:0] occ1;

  int n_chk;
  int n_fail;

  logic [23:0] exp_so;
  logic [23:0] pat_in;

  dffnrnq_pipe #(.WIDTH(4), .DEPTH(3)) dut (
    .CLKN (clkn), .RN (rn), .D (d), .VIN (vin), .EN (en), .FLUSH (flush),
    .SE (se), .SI (si), .Q (q), .QV (qv), .SO (so), .OCC (occ)
  );

  dffnrnq_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
    .CLKN (clkn), .RN (rn), .D (d1), .VIN (vin1), .EN (en1), .FLUSH (flush1),
    .SE (se1), .SI (si1), .Q (q1), .QV (qv1), .SO (so1), .OCC (occ1)
  );

  initial clkn = 1'b1;
  always #5 clkn = ~clkn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clkn);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rn = 1'b0; d = 4'h0; vin = 1'b0; en = 1'b0; flush = 1'b0; se = 1'b0; si = 1'b0;
    d1 = 1'b0; vin1 = 1'b0; en1 = 1'b1; flush1 = 1'b0; se1 = 1'b0; si1 = 1'b0;
    tick();
    tick();
    check("rst_q", q, 0);
    check("rst_qv", qv, 0);
    check("rst_occ", occ, 0);
    rn = 1'b1;

    // Fill 5, A, 3
    en = 1'b1; vin = 1'b1; d = 4'h5;
    tick();
    check("fill1_qv", qv, 0);
    check("fill1_occ", occ, 1);
    d = 4'hA; tick();
    d = 4'h3; tick();
    check("fill3_q", q, 4'h5);
    check("fill3_qv", qv, 1);
    check("fill3_occ", occ, 3);

    // Stall
    en = 1'b0; d = 4'hF; vin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_q", q, 4'h5);
      check("stall_qv", qv, 1);
      check("stall_occ", occ, 3);
    end
    en = 1'b1; vin = 1'b0; d = 4'h0;
    tick();
    check("resume_q", q, 4'hA);
    check("resume_occ", occ, 2);

    // Refill with 1, 2, 4 then flush while advancing 8
    vin = 1'b1;
    d = 4'h1; tick();
    d = 4'h2; tick();
    d = 4'h4; tick();
    check("refill_occ", occ, 3);
    check("refill_q", q, 4'h1);
    flush = 1'b1; d = 4'h8;
    tick();
    check("flush_occ", occ, 0);
    check("flush_qv", qv, 0);
    check("flush_q", q, 4'h2);
    flush = 1'b0;

    // Build nonzero state with SO=1, then async reset between edges
    d = 4'h0; vin = 1'b1;
    tick();
    tick();
    check("pre_rst_q", q, 4'h8);
    check("pre_rst_so", so, 1);
    check("pre_rst_occ", occ, 2);
    #2 rn = 1'b0;
    #1;
    check("async_q", q, 0);
    check("async_qv", qv, 0);
    check("async_so", so, 0);
    check("async_occ", occ, 0);
    d = 4'hF; vin = 1'b1; en = 1'b1;
    tick();
    check("held_q", q, 0);
    check("held_occ", occ, 0);
    rn = 1'b1;

    // State {1,2,3} with valids {1,0,1} ahead of the scan
    d = 4'h1; vin = 1'b1; tick();
    d = 4'h2; vin = 1'b0; tick();
    d = 4'h3; vin = 1'b1; tick();
    check("prescan_occ", occ, 2);
    check("prescan_q", q, 4'h1);

    // Shift A5C in MSB first, then twelve zeros to read it back through SO
    se = 1'b1; en = 1'b0; d = 4'hF; vin = 1'b1;
    exp_so = {12'h123, 12'hA5C};
    pat_in = {12'hA5C, 12'h000};
    for (int j = 0; j < 24; j++) begin
      check("scan_so", so, exp_so[23-j]);
      si = pat_in[23-j];
      tick();
      if (j == 11) begin
        check("scan_q", q, 4'hA);
        check("scan_qv", qv, 1);
        check("scan_occ", occ, 2);
      end
    end
    check("scan_end_q", q, 0);

    // Flush during scan clears the tags
    flush = 1'b1; si = 1'b0;
    tick();
    check("sflush_occ", occ, 0);
    check("sflush_qv", qv, 0);
    flush = 1'b0;

    // Reset pulsed mid-scan, then one shift brings SI into bit0
    si = 1'b1;
    tick();
    tick();
    #2 rn = 1'b0;
    #1;
    check("mscan_q", q, 0);
    check("mscan_so", so, 0);
    check("mscan_occ", occ, 0);
    rn = 1'b1;
    si = 1'b1;
    tick();
    check("post_q", q, 0);
    se = 1'b0; si = 1'b0; en = 1'b1; vin = 1'b0; d = 4'h0;
    tick();
    tick();
    check("post_bit0_q", q, 4'h1);

    // DEPTH=1, WIDTH=1 instance
    d1 = 1'b1; vin1 = 1'b1;
    tick();
    check("d1_q_hi", q1, 1);
    check("d1_qv_hi", qv1, 1);
    check("d1_occ_hi", occ1, 1);
    check("d1_so_hi", so1, 1);
    d1 = 1'b0; vin1 = 1'b0;
    tick();
    check("d1_q_lo", q1, 0);
    check("d1_qv_lo", qv1, 0);
    check("d1_occ_lo", occ1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dffnrnq_pipe.md
DFFNRNQ_PIPE -- requirements
Module: dffnrnq_pipe

Interface
REQ-001 Parameter WIDTH, default 4, data bits per stage; legal range 1..32.
REQ-002 Parameter DEPTH, default 3, pipeline stages; legal range 1..16.
REQ-003 CLKN  input  1  clock; all state updates on falling edge.
REQ-004 RN  input  1  reset; asynchronous, active-low.
REQ-005 D  input  WIDTH  data into stage 0.
REQ-006 VIN  input  1  valid tag accompanying D.
REQ-007 EN  input  1  functional advance enable; 0 = hold.
REQ-008 FLUSH  input  1  synchronous clear of all valid tags.
REQ-009 SE  input  1  scan enable; overrides functional mode.
REQ-010 SI  input  1  scan serial input.
REQ-011 Q  output  WIDTH  data of last stage, DEPTH-1.
REQ-012 QV  output  1  valid tag of last stage.
REQ-013 SO  output  1  scan serial output, MSB of last-stage data.
REQ-014 OCC  output  $clog2(DEPTH+1)  count of stages currently holding a set valid tag.

Function
REQ-015 State: DEPTH data registers of WIDTH bits, plus DEPTH valid flops, all clocked on the falling edge of CLKN.
REQ-016 Functional advance (SE=0, EN=1): stage0 <= D, valid0 <= VIN; stage k <= stage k-1 and valid k <= valid k-1 for k=1..DEPTH-1.
REQ-017 Hold (SE=0, EN=0): all data and valid flops retain their values.
REQ-018 Latency: a D/VIN sampled on falling edge n appears on Q/QV after falling edge n+DEPTH-1, given EN=1 throughout; DEPTH=1 gives Q after the same edge.
REQ-019 Scan (SE=1): data flops form one chain of WIDTH*DEPTH bits; SI enters stage0 bit0; bit i feeds bit i+1 within a stage; stage k MSB feeds stage k+1 bit0; the chain shifts one position per falling edge regardless of EN; valid flops hold.
REQ-020 SO is the combinational image of stage DEPTH-1 bit WIDTH-1 in both modes.
REQ-021 FLUSH=1 on a falling edge clears all valid flops; it takes priority over advance and hold; data flops follow REQ-016/017/019 unchanged.
REQ-022 FLUSH together with SE=1: valid flops clear and data shifts as scan.
REQ-023 OCC is a registered population count, updated on the same falling edge as the valid flops; it equals the count of set valid flops at all times, range 0..DEPTH.
REQ-024 Q, QV and SO are driven directly from flops, with no combinational path from D, VIN or EN.

Reset
REQ-025 RN=0 immediately clears all data flops, valid flops and OCC, independent of CLKN; Q=0, QV=0, SO=0, OCC=0.
REQ-026 While RN=0, falling edges have no effect; the first update occurs on the first falling edge after RN rises.
REQ-027 RN asserted mid-operation (scan or functional) discards all in-flight data with no partial shift.

Structure
REQ-028 A shared package dffn_pkg holds WIDTH_MAX=32, DEPTH_MAX=16 and the occ-width function; the block uses no other shared types.
REQ-029 One sub-module, dffnrnq_stage, implements one WIDTH-bit falling-edge stage with async RN, EN/SE muxing and its valid flop; the top level instantiates it DEPTH times in a generate loop.
REQ-030 Parameter range violations are checked at elaboration and produce a fatal error.

Verification
REQ-031 Reset: RN=0 with nonzero state -> Q=0, QV=0, SO=0, OCC=0 before any clock edge.
REQ-032 Latency: WIDTH=4, DEPTH=3, EN=1, VIN=1, D=0x5,0xA,0x3 on successive falling edges -> Q=0x5 with QV=1 after the third edge, OCC=3.
REQ-033 Stall: same fill, then EN=0 for 4 edges -> Q, QV and OCC unchanged; EN=1 with VIN=0 -> next edge Q=0xA, OCC=2.
REQ-034 Flush: pipeline full (OCC=3), FLUSH=1 with EN=1, VIN=1 -> next edge all valid flops clear, OCC=0, QV=0, data advanced.
REQ-035 Scan: SE=1, shift 12 bits of 0xA5C in via SI, MSB first -> chain holds the pattern, SO emits the previous contents in order, and valid flops are unchanged.
REQ-036 Edge cases: DEPTH=1, WIDTH=1 -> Q follows D after a single falling edge; RN pulsed mid-scan -> all-zero state, first post-release edge shifts SI into bit0.
